// File: rtl/alu_control_fsm.sv
// alu_control_fsm: multi-cycle control sequencer for a single-issue ALU datapath.
// Accepts one instruction word at a time and walks IDLE -> DECODE -> EXEC ->
// (MEM) -> (WB). It drives the ALU control code, operand select, memory and
// write-back strobes, and registers the ALU flags for later conditional branches.
// Optional feature: define ALU_CTRL_MEM_TIMEOUT_EN to bound the wait for
// mem_ready to MEM_TIMEOUT cycles. A timeout pulses mem_error and abandons the access.
module alu_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  alu_control,
  output logic        alu_src_imm,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_sign,
  input  logic        alu_overflow,
  output logic [3:0]  flags,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ready,
  output logic        reg_write,
  output logic        pc_write,
  output logic        illegal,
  output logic        mem_error,
  output logic        busy
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CTL_W = 4;
  localparam int unsigned CNT_W = 8;

  // Opcodes
  localparam logic [OP_W-1:0] OP_ADD  = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h01;
  localparam logic [OP_W-1:0] OP_COMP = 6'h02;
  localparam logic [OP_W-1:0] OP_AND  = 6'h03;
  localparam logic [OP_W-1:0] OP_XOR  = 6'h04;
  localparam logic [OP_W-1:0] OP_SHL  = 6'h05;
  localparam logic [OP_W-1:0] OP_SHR  = 6'h06;
  localparam logic [OP_W-1:0] OP_SRA  = 6'h07;
  localparam logic [OP_W-1:0] OP_LW   = 6'h08;
  localparam logic [OP_W-1:0] OP_SW   = 6'h09;
  localparam logic [OP_W-1:0] OP_BR   = 6'h0A;
  localparam logic [OP_W-1:0] OP_BZ   = 6'h0B;
  localparam logic [OP_W-1:0] OP_BNZ  = 6'h0C;
  localparam logic [OP_W-1:0] OP_BCY  = 6'h0D;

  // ALU control codes
  localparam logic [CTL_W-1:0] CTL_ADD  = 4'b0000;
  localparam logic [CTL_W-1:0] CTL_COMP = 4'b0001;
  localparam logic [CTL_W-1:0] CTL_AND  = 4'b0010;
  localparam logic [CTL_W-1:0] CTL_XOR  = 4'b0011;
  localparam logic [CTL_W-1:0] CTL_SHL  = 4'b0100;
  localparam logic [CTL_W-1:0] CTL_SHR  = 4'b0101;
  localparam logic [CTL_W-1:0] CTL_SRA  = 4'b0110;
  localparam logic [CTL_W-1:0] CTL_CMPZ = 4'b0111;
  localparam logic [CTL_W-1:0] CTL_BR   = 4'b1000;
  localparam logic [CTL_W-1:0] CTL_ADDR = 4'b1001;
  localparam logic [CTL_W-1:0] CTL_NOP  = 4'b1111;

  // Terminal value of the MEM wait counter
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [OP_W-1:0] op_q;
  logic            accept;
  logic            flags_load;
  logic            mem_timeout;
  logic            instr_unused;

  // Only the opcode steers the sequencer; operand fields belong to the datapath
  assign instr_unused = ^instr[25:0];

  // Opcode to ALU control code
  function automatic logic [CTL_W-1:0] alu_code(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_ADDI:       alu_code = CTL_ADD;
      OP_COMP:               alu_code = CTL_COMP;
      OP_AND:                alu_code = CTL_AND;
      OP_XOR:                alu_code = CTL_XOR;
      OP_SHL:                alu_code = CTL_SHL;
      OP_SHR:                alu_code = CTL_SHR;
      OP_SRA:                alu_code = CTL_SRA;
      OP_LW, OP_SW:          alu_code = CTL_ADDR;
      OP_BR:                 alu_code = CTL_BR;
      OP_BZ, OP_BNZ, OP_BCY: alu_code = CTL_CMPZ;
      default:               alu_code = CTL_NOP;
    endcase
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    op_legal = (op <= OP_BCY);
  endfunction

  function automatic logic op_is_alu(input logic [OP_W-1:0] op);
    op_is_alu = (op <= OP_SRA);
  endfunction

  function automatic logic op_is_mem(input logic [OP_W-1:0] op);
    op_is_mem = (op == OP_LW) || (op == OP_SW);
  endfunction

  // Branch resolution: BR unconditional, BZ/BNZ on live zero, BCY on stored carry
  function automatic logic branch_taken(input logic [OP_W-1:0] op,
                                        input logic            zero,
                                        input logic            carry_q);
    case (op)
      OP_BR:   branch_taken = 1'b1;
      OP_BZ:   branch_taken = zero;
      OP_BNZ:  branch_taken = ~zero;
      OP_BCY:  branch_taken = carry_q;
      default: branch_taken = 1'b0;
    endcase
  endfunction

`ifdef ALU_CTRL_MEM_TIMEOUT_EN
  logic [CNT_W-1:0] mem_cnt;

  // MEM wait counter: zero on MEM entry, +1 for every MEM cycle
  always_ff @(posedge clk) begin
    if (rst || (state != S_MEM)) begin
      mem_cnt <= '0;
    end else begin
      mem_cnt <= mem_cnt + CNT_W'(1);
    end
  end

  // Fires in the MEM_TIMEOUT-th MEM cycle; a same-cycle mem_ready takes priority
  assign mem_timeout = (state == S_MEM) && !mem_ready &&
                       (mem_cnt == (TIMEOUT_CNT - CNT_W'(1)));
`else
  logic timeout_unused;

  assign timeout_unused = ^TIMEOUT_CNT;
  assign mem_timeout    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Opcode latch on the acceptance edge; instr need not be held afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
    end else if (accept) begin
      op_q <= instr[31:26];
    end
  end

  // Flag register, written only when an ALU-class instruction leaves EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else if (flags_load) begin
      flags <= {alu_carry, alu_zero, alu_sign, alu_overflow};
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    alu_control = CTL_NOP;
    alu_src_imm = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    pc_write    = 1'b0;
    illegal     = 1'b0;
    mem_error   = 1'b0;
    flags_load  = 1'b0;
    busy        = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        instr_ready = ~rst;
        accept      = instr_valid & ~rst;
        if (accept) begin
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        if (op_legal(op_q)) begin
          state_nxt = S_EXEC;
        end else begin
          illegal   = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      S_EXEC: begin
        alu_control = alu_code(op_q);
        alu_src_imm = (op_q == OP_ADDI);
        if (op_is_alu(op_q)) begin
          flags_load = 1'b1;
          state_nxt  = S_WB;
        end else if (op_is_mem(op_q)) begin
          state_nxt = S_MEM;
        end else begin
          pc_write  = branch_taken(op_q, alu_zero, flags[3]);
          state_nxt = S_IDLE;
        end
      end

      S_MEM: begin
        // Address code held so the effective address stays stable
        alu_control = alu_code(op_q);
        mem_read    = (op_q == OP_LW);
        mem_write   = (op_q == OP_SW);
        if (mem_ready) begin
          state_nxt = (op_q == OP_LW) ? S_WB : S_IDLE;
        end else if (mem_timeout) begin
          mem_error = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // An instruction aborted by reset issues no commit or error pulses
    reg_write = reg_write & ~rst;
    pc_write  = pc_write  & ~rst;
    illegal   = illegal   & ~rst;
    mem_error = mem_error & ~rst;
  end

endmodule
